imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: receives a program image as a byte stream and writes it word by word into instruction memory.
- Holds the CPU (cpuHold) while loading and releases it only after a verified, complete image.
- Sits between a byte source (UART receiver or testbench) and the instruction memory write port (we/addr/dIn).

Parameters:
ADDR_BASE, 32'h0, byte address of the first word written.
MAX_WORDS, 1024, largest accepted word count; anything larger is an error.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; restarts the loader
byteIn  input  8  incoming stream byte
byteValid  input  1  byteIn valid this cycle
byteReady  output  1  loader accepts byteIn this cycle
start  input  1  single-cycle pulse; restarts a load from DONE or ERR
memWe  output  1  instruction memory write enable, one-cycle pulse per word
memAddr  output  32  byte address of the word being written
memDIn  output  32  word being written
cpuHold  output  1  CPU held while 1
done  output  1  sticky: image loaded and checksum matched
error  output  1  sticky: length or checksum failure

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset is asynchronous, active-high.
  - While reset is high: state=LEN_HI, memWe=0, memAddr=ADDR_BASE, memDIn=0, cpuHold=1, done=0, error=0, word index=0, checksum=0.
  - byteReady is combinational from state.
- Byte acceptance and stream format:
  - A byte is accepted on a rising edge where byteValid && byteReady.
  - Stream format, all big-endian: length hi, length lo (16-bit word count N), N×4 word bytes, 1 checksum byte.
  - Checksum = XOR of every byte before the checksum byte, including both length bytes.
- States:
  - LEN_HI: byteReady=1; on accept, latch length[15:8] → LEN_LO.
  - LEN_LO: byteReady=1; on accept, latch length[7:0].
    - If N > MAX_WORDS → ERR.
    - If N == 0 → CHECK.
    - Otherwise → WORD.
  - WORD: byteReady=1; a 2-bit byte counter shifts bytes into a 32-bit assembly register, MSB first.
    - On the 4th accepted byte, on the next edge: memWe=1 for exactly one cycle, memDIn=assembled word, memAddr=ADDR_BASE + 4×index.
    - Index increments after each write.
    - After the write of word N-1 → CHECK.
  - CHECK: byteReady=1; on accept, compare the byte with the running XOR.
    - Match → DONE.
    - Mismatch → ERR.
  - DONE: byteReady=0, cpuHold=0, done=1. start → LEN_HI.
  - ERR: byteReady=0, cpuHold=1, error=1. start → LEN_HI.
- Latency and throughput:
  - memWe asserts 1 cycle after the 4th byte of a word is accepted.
  - The loader sustains one byte per cycle with no backpressure; byteReady never drops mid-image.
  - A byte accepted in the same cycle as a memWe pulse is part of the next word and must not be lost.
- Outputs outside a write:
  - memAddr and memDIn hold their last values between writes.
  - memWe=0 in every cycle other than a write pulse.
- Restart with start:
  - Clears done, error, checksum, index; sets cpuHold=1; memAddr=ADDR_BASE.
  - start is ignored in LEN_HI, LEN_LO, WORD and CHECK.
- Boundaries:
  - Gaps in byteValid at any point, including between bytes of one word, stall the state without side effects.
  - N == MAX_WORDS is legal.
  - The word index is 16 bits wide; memAddr arithmetic is 32-bit and wraps modulo 2^32.
  - Reset asserted mid-word discards the partial word; no memWe pulse is emitted for it.
  - Words written before an ERR are left in memory; cpuHold stays 1.

Test Plan:
- Normal load: reset, then stream 00 02 20 08 00 05 00 00 00 00 2F with byteValid held high.
  - Required: memWe pulses at addr 0x0 with data 0x20080005, then at addr 0x4 with data 0x00000000.
  - Then done=1, cpuHold=0, error=0.
- Bad checksum: same stream but last byte 0x30.
  - Required: both writes occur, then error=1, cpuHold=1, done=0.
- Empty and over-length images:
  - Stream 00 00 00 → done=1 with no memWe pulse.
  - Stream 04 01 (N=1025) → error=1 immediately after LEN_LO; byteReady=0.
- Backpressure: first scenario with byteValid toggling 1/0 every cycle and 3-cycle gaps inside each word.
  - Required: identical writes and done result; memWe is still a single-cycle pulse per word.
- Reset and restart:
  - Assert reset after 2 bytes of the first word → all outputs at reset values and no write.
  - After an ERR, pulse start and send a valid image with ADDR_BASE=0x400 → writes at 0x400 and 0x404, then done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed, XOR-checksummed byte stream
// and writes it word by word into instruction memory, holding the CPU until verified.
module imem_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic        byteReady,
    input  logic        start,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memDIn,
    output logic        cpuHold,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] LEN_HI = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] WORD   = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] ERR    = 3'd5;

    logic [2:0]  state;
    logic [15:0] len;
    logic [15:0] idx;
    logic [1:0]  bcnt;
    logic [23:0] asm_word;
    logic [7:0]  csum;
    logic        accept;
    logic [31:0] len_next;

    assign byteReady = (state == LEN_HI) || (state == LEN_LO) ||
                       (state == WORD)   || (state == CHECK);
    assign accept    = byteValid && byteReady;
    assign len_next  = {16'h0, len[15:8], byteIn};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= LEN_HI;
            len      <= '0;
            idx      <= '0;
            bcnt     <= '0;
            asm_word <= '0;
            csum     <= '0;
            memWe    <= 1'b0;
            memAddr  <= ADDR_BASE;
            memDIn   <= '0;
            cpuHold  <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            memWe <= 1'b0;
            case (state)
                LEN_HI: if (accept) begin
                    len[15:8] <= byteIn;
                    csum      <= csum ^ byteIn;
                    state     <= LEN_LO;
                end
                LEN_LO: if (accept) begin
                    len[7:0] <= byteIn;
                    csum     <= csum ^ byteIn;
                    if (len_next > 32'(MAX_WORDS)) begin
                        state <= ERR;
                        error <= 1'b1;
                    end else if (len_next == 32'd0) begin
                        state <= CHECK;
                    end else begin
                        state <= WORD;
                    end
                end
                WORD: if (accept) begin
                    csum     <= csum ^ byteIn;
                    bcnt     <= bcnt + 2'd1;
                    asm_word <= {asm_word[15:0], byteIn};
                    // Fourth byte completes the word; the write pulse lands next cycle
                    // while the following byte can already be accepted.
                    if (bcnt == 2'd3) begin
                        memWe   <= 1'b1;
                        memDIn  <= {asm_word, byteIn};
                        memAddr <= ADDR_BASE + {14'h0, idx, 2'b00};
                        idx     <= idx + 16'd1;
                        if ((idx + 16'd1) == len)
                            state <= CHECK;
                    end
                end
                CHECK: if (accept) begin
                    if (byteIn == csum) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        cpuHold <= 1'b0;
                    end else begin
                        state <= ERR;
                        error <= 1'b1;
                    end
                end
                DONE, ERR: if (start) begin
                    state   <= LEN_HI;
                    done    <= 1'b0;
                    error   <= 1'b0;
                    csum    <= '0;
                    idx     <= '0;
                    bcnt    <= '0;
                    cpuHold <= 1'b1;
                    memAddr <= ADDR_BASE;
                end
                default: begin
                    state <= ERR;
                    error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (different base / max length) share
// one byte source; a stream-parsing reference model predicts writes and final status.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        start;
    logic        br [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] din [2];
    logic        hold [2];
    logic        dn [2];
    logic        er [2];

    int checks = 0;
    int errors = 0;

    logic [7:0]  img [$];
    logic [63:0] got0 [$];
    logic [63:0] got1 [$];
    logic [63:0] expq [$];
    bit          prev_we [2];
    bit          dbl [2];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_BASE(32'h0), .MAX_WORDS(1024)) dut_a (
        .clk(clk), .reset(reset), .byteIn(byteIn), .byteValid(byteValid),
        .byteReady(br[0]), .start(start), .memWe(we[0]), .memAddr(addr[0]),
        .memDIn(din[0]), .cpuHold(hold[0]), .done(dn[0]), .error(er[0]));

    imem_loader #(.ADDR_BASE(32'h400), .MAX_WORDS(3)) dut_b (
        .clk(clk), .reset(reset), .byteIn(byteIn), .byteValid(byteValid),
        .byteReady(br[1]), .start(start), .memWe(we[1]), .memAddr(addr[1]),
        .memDIn(din[1]), .cpuHold(hold[1]), .done(dn[1]), .error(er[1]));

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0 : 32'h400;
    endfunction

    function automatic int maxw_of(input int d);
        return (d == 0) ? 1024 : 3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we[0]) got0.push_back({addr[0], din[0]});
        if (we[1]) got1.push_back({addr[1], din[1]});
        for (int d = 0; d < 2; d++) begin
            if (prev_we[d] && we[d]) dbl[d] = 1'b1;
            prev_we[d] = we[d];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs;
        got0.delete();
        got1.delete();
        dbl[0] = 1'b0;
        dbl[1] = 1'b0;
    endtask

    task automatic chk_reset(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s/d%0d/ready", nm, d), 64'(br[d]), 64'd1);
            chk($sformatf("%s/d%0d/we", nm, d), 64'(we[d]), 64'd0);
            chk($sformatf("%s/d%0d/addr", nm, d), 64'(addr[d]), 64'(base_of(d)));
            chk($sformatf("%s/d%0d/din", nm, d), 64'(din[d]), 64'd0);
            chk($sformatf("%s/d%0d/hold", nm, d), 64'(hold[d]), 64'd1);
            chk($sformatf("%s/d%0d/done", nm, d), 64'(dn[d]), 64'd0);
            chk($sformatf("%s/d%0d/err", nm, d), 64'(er[d]), 64'd0);
        end
    endtask

    task automatic restart(input bit use_reset);
        if (use_reset) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
        end else begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        clear_obs();
    endtask

    // mode 0: back-to-back, 1: toggle + 3-cycle gap mid-word, 2: random gaps and stray starts
    task automatic send(input int mode);
        for (int i = 0; i < img.size(); i++) begin
            byteIn    = img[i];
            byteValid = 1'b1;
            if (mode == 2 && i < 2) start = ($urandom_range(0, 3) == 0);
            tick();
            start     = 1'b0;
            byteValid = 1'b0;
            byteIn    = 8'($urandom);
            if (mode == 1) begin
                tick();
                if (i >= 2 && ((i - 2) % 4) == 1) repeat (3) tick();
            end else if (mode == 2 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        repeat (3) tick();
    endtask

    // Reference: parse the whole image as a byte list and derive writes and status.
    task automatic model(input int d, output bit edone, output bit eerr);
        int          n;
        logic [7:0]  ck;
        logic [31:0] w;
        expq.delete();
        n = {img[0], img[1]};
        if (n > maxw_of(d)) begin
            edone = 1'b0;
            eerr  = 1'b1;
            return;
        end
        ck = 8'h0;
        for (int j = 0; j < 2 + 4 * n; j++) ck ^= img[j];
        for (int k = 0; k < n; k++) begin
            w = {img[2+4*k], img[3+4*k], img[4+4*k], img[5+4*k]};
            expq.push_back({base_of(d) + 32'(4 * k), w});
        end
        edone = (img[2+4*n] == ck);
        eerr  = !edone;
    endtask

    task automatic verify(input string nm);
        bit          edone;
        bit          eerr;
        logic [63:0] g [$];
        int          m;
        for (int d = 0; d < 2; d++) begin
            model(d, edone, eerr);
            g = (d == 0) ? got0 : got1;
            chk($sformatf("%s/d%0d/nwrites", nm, d), 64'(g.size()), 64'(expq.size()));
            m = (g.size() < expq.size()) ? g.size() : expq.size();
            for (int i = 0; i < m; i++)
                chk($sformatf("%s/d%0d/write%0d", nm, d, i), g[i], expq[i]);
            chk($sformatf("%s/d%0d/done", nm, d), 64'(dn[d]), 64'(edone));
            chk($sformatf("%s/d%0d/err", nm, d), 64'(er[d]), 64'(eerr));
            chk($sformatf("%s/d%0d/hold", nm, d), 64'(hold[d]), 64'(!edone));
            chk($sformatf("%s/d%0d/ready", nm, d), 64'(br[d]), 64'd0);
            chk($sformatf("%s/d%0d/single_we", nm, d), 64'(dbl[d]), 64'd0);
        end
    endtask

    task automatic load_normal(input logic [7:0] last);
        img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h00, 8'h00, 8'h00, 8'h00, last};
    endtask

    initial begin
        int          n;
        logic [7:0]  ck;
        reset     = 1'b1;
        byteValid = 1'b0;
        byteIn    = 8'h0;
        start     = 1'b0;
        clear_obs();
        #1;
        chk_reset("por");
        tick();
        reset = 1'b0;

        load_normal(8'h2F);
        send(0);
        verify("normal");

        restart(1'b0);
        load_normal(8'h30);
        send(0);
        verify("badck");

        restart(1'b0);
        img = '{8'h00, 8'h00, 8'h00};
        send(0);
        verify("empty");

        restart(1'b0);
        img = '{8'h04, 8'h01};
        send(0);
        verify("overlen");

        restart(1'b0);
        load_normal(8'h2F);
        send(1);
        verify("backpressure");

        // Reset two bytes into the first word: partial word must vanish.
        restart(1'b0);
        img = '{8'h00, 8'h02, 8'h20, 8'h08};
        send(0);
        reset = 1'b1;
        #1;
        chk_reset("midreset");
        tick();
        reset = 1'b0;
        chk("midreset/nwrites_a", 64'(got0.size()), 64'd0);
        chk("midreset/nwrites_b", 64'(got1.size()), 64'd0);
        clear_obs();
        load_normal(8'h2F);
        send(2);
        verify("after_reset");

        // Maximum-length image for the large instance; the small one rejects it.
        restart(1'b0);
        img = '{8'h04, 8'h00};
        ck  = 8'h04;
        for (int i = 0; i < 4096; i++) begin
            img.push_back(8'($urandom));
            ck ^= img[img.size()-1];
        end
        img.push_back(ck);
        send(0);
        verify("maxlen");

        for (int it = 0; it < 40; it++) begin
            restart($urandom_range(0, 4) == 0);
            n   = $urandom_range(0, 5);
            img = '{8'h00, 8'(n)};
            ck  = 8'(n);
            for (int i = 0; i < 4 * n; i++) begin
                img.push_back(8'($urandom));
                ck ^= img[img.size()-1];
            end
            if ($urandom_range(0, 3) == 0) ck ^= 8'($urandom_range(1, 255));
            img.push_back(ck);
            send(2);
            verify($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
